// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } arb_state_e;

    localparam logic GNT_CPU = 1'b0;
    localparam logic GNT_LDR = 1'b1;

    localparam int WAIT_CYCLES_MIN = 0;
    localparam int WAIT_CYCLES_MAX = 15;
    localparam int WCNT_W          = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// One requester port of the arbiter: request fields in, read data and ready pulse out.
interface mem_port_arbiter_if #(parameter int ADDR_W = 32);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [31:0]       rdata;
    logic              ready;

    modport master (output req, we, addr, wdata, input rdata, ready);
    modport slave  (input req, we, addr, wdata, output rdata, ready);
endinterface

// File: rtl/mem_port_arbiter_wait_counter.sv
// Down-counter that times the WAIT state; zero flags the last wait cycle.
module mem_wait_counter
    import mem_arb_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [WCNT_W-1:0] load_val,
    input  logic              dec,
    output logic              zero
);
    logic [WCNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!reset)    cnt <= '0;
        else if (load) cnt <= load_val;
        else if (dec)  cnt <= cnt - 1'b1;
    end

    assign zero = (cnt == '0);
endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port (core / program loader) arbiter onto a single-ported memory.
// Define ARB_ROUND_ROBIN_EN for alternating grants; default is loader-first fixed priority.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int WAIT_CYCLES = 1,
    parameter int ADDR_W      = 32
) (
    input  logic               clk,
    input  logic               reset,
    mem_port_arbiter_if.slave  cpu,
    mem_port_arbiter_if.slave  ldr,
    output logic               cpu_stall,
    output logic               mem_en,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [31:0]        mem_wdata,
    input  logic [31:0]        mem_rdata
);
    if (WAIT_CYCLES < WAIT_CYCLES_MIN || WAIT_CYCLES > WAIT_CYCLES_MAX) begin : g_bad_wait
        $error("WAIT_CYCLES out of range");
    end

    // Counter is loaded on entry to WAIT, so it starts one below the wait length.
    localparam logic [WCNT_W-1:0] WAIT_LOAD =
        (WAIT_CYCLES > 0) ? WCNT_W'(WAIT_CYCLES - 1) : '0;

    arb_state_e        state;
    logic              gnt_q, gnt_sel;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       cpu_rdata_q, ldr_rdata_q;
    logic              cpu_ready_q, ldr_ready_q;
    logic              cnt_zero, last_cyc;

`ifdef ARB_ROUND_ROBIN_EN
    logic rr_q;
`endif

    always_comb begin
        gnt_sel = GNT_CPU;
        if (cpu.req && ldr.req) begin
`ifdef ARB_ROUND_ROBIN_EN
            gnt_sel = rr_q;
`else
            gnt_sel = GNT_LDR;
`endif
        end else if (ldr.req) begin
            gnt_sel = GNT_LDR;
        end
    end

    // Final memory cycle: mem_rdata is sampled on the edge that ends it.
    assign last_cyc = (state == ACCESS && WAIT_CYCLES == 0) || (state == WAIT && cnt_zero);

    mem_wait_counter u_wait (
        .clk      (clk),
        .reset    (reset),
        .load     (state == ACCESS),
        .load_val (WAIT_LOAD),
        .dec      (state == WAIT && !cnt_zero),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            gnt_q       <= GNT_CPU;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cpu_rdata_q <= '0;
            ldr_rdata_q <= '0;
            cpu_ready_q <= 1'b0;
            ldr_ready_q <= 1'b0;
            mem_en      <= 1'b0;
            mem_we      <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            rr_q        <= GNT_CPU;
`endif
        end else begin
            cpu_ready_q <= 1'b0;
            ldr_ready_q <= 1'b0;
            case (state)
                IDLE: if (cpu.req || ldr.req) begin
                    gnt_q   <= gnt_sel;
                    we_q    <= gnt_sel ? ldr.we    : cpu.we;
                    addr_q  <= gnt_sel ? ldr.addr  : cpu.addr;
                    wdata_q <= gnt_sel ? ldr.wdata : cpu.wdata;
                    mem_en  <= 1'b1;
                    mem_we  <= gnt_sel ? ldr.we    : cpu.we;
`ifdef ARB_ROUND_ROBIN_EN
                    rr_q    <= ~gnt_sel;
`endif
                    state   <= ACCESS;
                end
                ACCESS:  state <= last_cyc ? DONE : WAIT;
                WAIT:    if (last_cyc) state <= DONE;
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
            if (last_cyc) begin
                mem_en <= 1'b0;
                mem_we <= 1'b0;
                if (gnt_q == GNT_LDR) begin
                    ldr_rdata_q <= mem_rdata;
                    ldr_ready_q <= 1'b1;
                end else begin
                    cpu_rdata_q <= mem_rdata;
                    cpu_ready_q <= 1'b1;
                end
            end
        end
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign cpu.rdata = cpu_rdata_q;
    assign cpu.ready = cpu_ready_q;
    assign ldr.rdata = ldr_rdata_q;
    assign ldr.ready = ldr_ready_q;
    assign cpu_stall = cpu.req & ~cpu_ready_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: one WAIT_CYCLES=1 instance (dut) and one WAIT_CYCLES=0 instance (dut0).
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(32)) cpu1 (), ldr1 (), cpu0 (), ldr0 ();

    logic        stall1, en1, we1, stall0, en0, we0;
    logic [31:0] addr1, wdata1, rdata1, addr0, wdata0, rdata0;

    // Memory model: 0x10 holds 0xDEADBEEF, everything else reads as ~addr.
    assign rdata1 = (addr1 == 32'h10) ? 32'hDEADBEEF : ~addr1;
    assign rdata0 = (addr0 == 32'h10) ? 32'hDEADBEEF : ~addr0;

    mem_port_arbiter #(.WAIT_CYCLES(1), .ADDR_W(32)) dut (
        .clk(clk), .reset(reset), .cpu(cpu1), .ldr(ldr1), .cpu_stall(stall1),
        .mem_en(en1), .mem_we(we1), .mem_addr(addr1), .mem_wdata(wdata1), .mem_rdata(rdata1));

    mem_port_arbiter #(.WAIT_CYCLES(0), .ADDR_W(32)) dut0 (
        .clk(clk), .reset(reset), .cpu(cpu0), .ldr(ldr0), .cpu_stall(stall0),
        .mem_en(en0), .mem_we(we0), .mem_addr(addr0), .mem_wdata(wdata0), .mem_rdata(rdata0));

    int nvec = 0;
    int nerr = 0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        cpu1.req = 0; cpu1.we = 0; cpu1.addr = 0; cpu1.wdata = 0;
        ldr1.req = 0; ldr1.we = 0; ldr1.addr = 0; ldr1.wdata = 0;
        cpu0.req = 0; cpu0.we = 0; cpu0.addr = 0; cpu0.wdata = 0;
        ldr0.req = 0; ldr0.we = 0; ldr0.addr = 0; ldr0.wdata = 0;
    endtask

    task automatic do_reset;
        idle_inputs();
        reset = 0;
        tick(); tick();
        reset = 1;
    endtask

    task automatic test_reset;
        idle_inputs();
        reset = 0;
        tick(); tick();
        nvec++; if (dut.state !== IDLE) begin nerr++; $display("FAIL rst_state got=%0d exp=%0d", dut.state, IDLE); end
        nvec++; if (cpu1.ready !== 1'b0) begin nerr++; $display("FAIL rst_cpu_ready got=%b exp=0", cpu1.ready); end
        nvec++; if (ldr1.ready !== 1'b0) begin nerr++; $display("FAIL rst_ldr_ready got=%b exp=0", ldr1.ready); end
        nvec++; if (cpu1.rdata !== 32'h0) begin nerr++; $display("FAIL rst_cpu_rdata got=%h exp=0", cpu1.rdata); end
        nvec++; if (ldr1.rdata !== 32'h0) begin nerr++; $display("FAIL rst_ldr_rdata got=%h exp=0", ldr1.rdata); end
        nvec++; if ({en1, we1} !== 2'b00) begin nerr++; $display("FAIL rst_mem_en_we got=%b exp=00", {en1, we1}); end
        nvec++; if ({addr1, wdata1} !== 64'h0) begin nerr++; $display("FAIL rst_mem_bus got=%h exp=0", {addr1, wdata1}); end
        nvec++; if ({stall1, en0, we0} !== 3'b000) begin nerr++; $display("FAIL rst_misc got=%b exp=000", {stall1, en0, we0}); end
        reset = 1;
    endtask

    task automatic test_cpu_read;
        int rdy_cyc = -1, en_cnt = 0, rdy_cnt = 0;
        logic [31:0] got = 0;
        cpu1.req = 1; cpu1.we = 0; cpu1.addr = 32'h10;
        for (int c = 1; c <= 6; c++) begin
            tick();
            if (en1) en_cnt++;
            if (cpu1.ready) begin
                rdy_cnt++;
                if (rdy_cyc < 0) rdy_cyc = c;
                got = cpu1.rdata;
                cpu1.req = 0;
            end
        end
        nvec++; if (rdy_cyc != 3) begin nerr++; $display("FAIL rd_ready_cycle got=%0d exp=3", rdy_cyc); end
        nvec++; if (got !== 32'hDEADBEEF) begin nerr++; $display("FAIL rd_data got=%h exp=deadbeef", got); end
        nvec++; if (en_cnt != 2) begin nerr++; $display("FAIL rd_mem_en_cycles got=%0d exp=2", en_cnt); end
        nvec++; if (rdy_cnt != 1) begin nerr++; $display("FAIL rd_ready_pulses got=%0d exp=1", rdy_cnt); end
    endtask

    task automatic test_ldr_write;
        int rdy_cyc = -1, we_cnt = 0, cpu_rdy = 0;
        logic [31:0] wa = 32'hFFFFFFFF, wd = 0;
        ldr0.req = 1; ldr0.we = 1; ldr0.addr = 32'h0; ldr0.wdata = 32'h13;
        for (int c = 1; c <= 5; c++) begin
            tick();
            if (we0) begin we_cnt++; wa = addr0; wd = wdata0; end
            if (cpu0.ready) cpu_rdy++;
            if (ldr0.ready) begin
                if (rdy_cyc < 0) rdy_cyc = c;
                ldr0.req = 0;
            end
        end
        nvec++; if (we_cnt != 1) begin nerr++; $display("FAIL wr_we_cycles got=%0d exp=1", we_cnt); end
        nvec++; if (wa !== 32'h0) begin nerr++; $display("FAIL wr_addr got=%h exp=0", wa); end
        nvec++; if (wd !== 32'h13) begin nerr++; $display("FAIL wr_data got=%h exp=13", wd); end
        nvec++; if (rdy_cyc != 2) begin nerr++; $display("FAIL wr_ready_cycle got=%0d exp=2", rdy_cyc); end
        nvec++; if (cpu_rdy != 0) begin nerr++; $display("FAIL wr_cpu_ready got=%0d exp=0", cpu_rdy); end
    endtask

    task automatic test_arbitration;
        logic exp_g [4];
        logic got_g [4];
        int   ng = 0;
        logic primed = 0;
        logic [31:0] exp_cpu_rdata;
        logic exp_stall;
`ifdef ARB_ROUND_ROBIN_EN
        exp_g = '{GNT_LDR, GNT_CPU, GNT_LDR, GNT_CPU};
        exp_cpu_rdata = 32'hFFFFFFF7;
        exp_stall = 1'b0;
`else
        exp_g = '{GNT_LDR, GNT_LDR, GNT_LDR, GNT_LDR};
        exp_cpu_rdata = 32'hFFFFFFFB;
        exp_stall = 1'b1;
`endif
        do_reset();
        // A lone CPU grant first, so the next simultaneous request favours the loader.
        cpu1.req = 1; cpu1.we = 0; cpu1.addr = 32'h4;
        for (int c = 1; c <= 6 && !primed; c++) begin
            tick();
            if (cpu1.ready) begin
                primed = 1;
                cpu1.addr = 32'h8;
                ldr1.req = 1; ldr1.we = 0; ldr1.addr = 32'h10;
            end
        end
        nvec++; if (primed !== 1'b1) begin nerr++; $display("FAIL arb_prime got=%b exp=1", primed); end
        for (int c = 1; c <= 16; c++) begin
            tick();
            if (cpu1.ready || ldr1.ready) begin
                if (ng < 4) got_g[ng] = ldr1.ready ? GNT_LDR : GNT_CPU;
                ng++;
                if (cpu1.ready && ldr1.ready) begin
                    nvec++; nerr++; $display("FAIL arb_both_ready got=11 exp=one-hot");
                end
                if (ldr1.ready) begin
                    nvec++; if (ldr1.rdata !== 32'hDEADBEEF) begin nerr++; $display("FAIL arb_ldr_rdata got=%h exp=deadbeef", ldr1.rdata); end
                end
                if (cpu1.ready) begin
                    nvec++; if (cpu1.rdata !== 32'hFFFFFFF7) begin nerr++; $display("FAIL arb_cpu_rdata got=%h exp=fffffff7", cpu1.rdata); end
                end
            end
        end
        nvec++; if (ng != 4) begin nerr++; $display("FAIL arb_grant_count got=%0d exp=4", ng); end
        for (int i = 0; i < 4 && i < ng; i++) begin
            nvec++; if (got_g[i] !== exp_g[i]) begin nerr++; $display("FAIL arb_grant%0d got=%b exp=%b", i, got_g[i], exp_g[i]); end
        end
        nvec++; if (cpu1.rdata !== exp_cpu_rdata) begin nerr++; $display("FAIL arb_cpu_rdata_hold got=%h exp=%h", cpu1.rdata, exp_cpu_rdata); end
        nvec++; if (stall1 !== exp_stall) begin nerr++; $display("FAIL arb_stall got=%b exp=%b", stall1, exp_stall); end
        idle_inputs();
        tick(); tick();
    endtask

    task automatic test_reset_mid_write;
        int rdy = 0;
        do_reset();
        cpu1.req = 1; cpu1.we = 1; cpu1.addr = 32'h20; cpu1.wdata = 32'h55;
        tick(); tick();
        nvec++; if (dut.state !== WAIT) begin nerr++; $display("FAIL rw_in_wait got=%0d exp=%0d", dut.state, WAIT); end
        nvec++; if (we1 !== 1'b1) begin nerr++; $display("FAIL rw_we_wait got=%b exp=1", we1); end
        reset = 0; cpu1.req = 0;
        tick();
        nvec++; if ({we1, en1} !== 2'b00) begin nerr++; $display("FAIL rw_we_en_after got=%b exp=00", {we1, en1}); end
        nvec++; if (dut.state !== IDLE) begin nerr++; $display("FAIL rw_state got=%0d exp=%0d", dut.state, IDLE); end
        nvec++; if ({addr1, wdata1} !== 64'h0) begin nerr++; $display("FAIL rw_latched got=%h exp=0", {addr1, wdata1}); end
        if (cpu1.ready) rdy++;
        reset = 1;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (cpu1.ready) rdy++;
        end
        nvec++; if (rdy != 0) begin nerr++; $display("FAIL rw_ready_pulses got=%0d exp=0", rdy); end
    endtask

    task automatic test_drop_req;
        int rdy_cyc = -1, rdy_cnt = 0, en_cnt = 0;
        logic [31:0] got = 0;
        cpu1.req = 1; cpu1.we = 0; cpu1.addr = 32'h4;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (c == 1) begin
                nvec++; if (dut.state !== ACCESS) begin nerr++; $display("FAIL drop_access got=%0d exp=%0d", dut.state, ACCESS); end
                cpu1.req = 0;
            end
            if (en1) en_cnt++;
            if (cpu1.ready) begin
                rdy_cnt++;
                if (rdy_cyc < 0) rdy_cyc = c;
                got = cpu1.rdata;
            end
        end
        nvec++; if (rdy_cnt != 1) begin nerr++; $display("FAIL drop_ready_pulses got=%0d exp=1", rdy_cnt); end
        nvec++; if (rdy_cyc != 3) begin nerr++; $display("FAIL drop_ready_cycle got=%0d exp=3", rdy_cyc); end
        nvec++; if (en_cnt != 2) begin nerr++; $display("FAIL drop_mem_en_cycles got=%0d exp=2", en_cnt); end
        nvec++; if (got !== 32'hFFFFFFFB) begin nerr++; $display("FAIL drop_rdata got=%h exp=fffffffb", got); end
    endtask

    task automatic test_back_to_back;
        int rc [2] = '{-1, -1};
        logic [31:0] rd [2] = '{32'h0, 32'h0};
        int nr = 0;
        logic exp_stall;
        cpu1.req = 1; cpu1.we = 0; cpu1.addr = 32'h4;
        for (int c = 1; c <= 10; c++) begin
            tick();
            exp_stall = (c < 7) && (c != 3);
            nvec++; if (stall1 !== exp_stall) begin nerr++; $display("FAIL b2b_stall c%0d got=%b exp=%b", c, stall1, exp_stall); end
            if (cpu1.ready) begin
                if (nr < 2) begin rc[nr] = c; rd[nr] = cpu1.rdata; end
                nr++;
                if (nr == 1) cpu1.addr = 32'h8;
                else cpu1.req = 0;
            end
        end
        nvec++; if (nr != 2) begin nerr++; $display("FAIL b2b_ready_count got=%0d exp=2", nr); end
        nvec++; if (rc[0] != 3 || rc[1] != 7) begin nerr++; $display("FAIL b2b_ready_cycles got=%0d,%0d exp=3,7", rc[0], rc[1]); end
        nvec++; if (rd[0] !== 32'hFFFFFFFB) begin nerr++; $display("FAIL b2b_rdata0 got=%h exp=fffffffb", rd[0]); end
        nvec++; if (rd[1] !== 32'hFFFFFFF7) begin nerr++; $display("FAIL b2b_rdata1 got=%h exp=fffffff7", rd[1]); end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_cpu_read();
        test_ldr_write();
        test_arbitration();
        test_reset_mid_write();
        test_drop_req();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter WAIT_CYCLES, default 1: extra memory latency cycles after the address cycle, legal range 0..15.
REQ-002 Parameter ADDR_W, default 32: address width for all ports.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 cpu_req  input  1  multicycle core requests a memory access.
REQ-006 cpu_we  input  1  core access is a write (1) or a read (0).
REQ-007 cpu_addr  input  ADDR_W  core byte address.
REQ-008 cpu_wdata  input  32  core write data.
REQ-009 cpu_rdata  output  32  core read data; valid while cpu_ready=1.
REQ-010 cpu_ready  output  1  one-cycle completion pulse to the core.
REQ-011 cpu_stall  output  1  high from core request until completion; the core gates PCWrite and IRWrite with it.
REQ-012 ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_rdata, ldr_ready  same directions and widths as the cpu_* ports; program-loader port.
REQ-013 mem_en  output  1  memory access enable.
REQ-014 mem_we  output  1  memory write strobe.
REQ-015 mem_addr  output  ADDR_W  memory address.
REQ-016 mem_wdata  output  32  memory write data.
REQ-017 mem_rdata  input  32  memory read data.

Function
REQ-018 The FSM SHALL have the states IDLE, ACCESS, WAIT and DONE.
REQ-019 In IDLE, when a request is sampled, the arbiter SHALL grant it, latch we/addr/wdata into internal registers, and move to ACCESS; with no request it SHALL stay in IDLE.
REQ-020 In ACCESS and WAIT, mem_en=1, mem_addr/mem_wdata come from the latched registers, and mem_we equals the latched we.
REQ-021 ACCESS SHALL go to WAIT when WAIT_CYCLES>0, otherwise directly to DONE.
REQ-022 The FSM SHALL stay in WAIT for exactly WAIT_CYCLES cycles, then go to DONE.
REQ-023 mem_rdata SHALL be captured on the edge leaving the last ACCESS/WAIT cycle.
REQ-024 In DONE the granted port's ready=1 for exactly one cycle, and its rdata holds the captured data (writes also pulse ready); the FSM then returns to IDLE.
REQ-025 Latency: a request sampled in IDLE at cycle 0 SHALL see ready at cycle 2+WAIT_CYCLES.
REQ-026 A requester SHALL hold req and its fields until ready; req still high in the IDLE cycle after DONE counts as a new request.
REQ-027 Deasserting req mid-transaction SHALL NOT abort it; ready still pulses.
REQ-028 cpu_stall = cpu_req AND NOT cpu_ready.
REQ-029 The non-granted port SHALL see ready=0, and its rdata keeps its last value.
REQ-030 In IDLE and DONE, mem_en and mem_we SHALL be 0.

Reset
REQ-031 When reset=0 at a clock edge, the FSM SHALL go to IDLE.
REQ-032 On that reset, all outputs, latched fields, the wait counter and the captured data SHALL become 0, and the round-robin pointer SHALL favour the CPU.
REQ-033 A reset mid-transaction SHALL abandon the access with no ready pulse, and mem_we SHALL be 0 from the next cycle.

Configuration
REQ-034 With ARB_ROUND_ROBIN_EN defined, simultaneous requests SHALL alternate grants: the pointer toggles to the other port after every grant.
REQ-035 Without ARB_ROUND_ROBIN_EN, the loader SHALL always win simultaneous requests (fixed priority), and no pointer register exists.

Structure
REQ-036 A shared package mem_arb_pkg SHALL hold the state enum, the grant encoding (GNT_CPU=0, GNT_LDR=1) and the WAIT_CYCLES bounds constants.
REQ-037 The wait counter SHALL be a sub-module mem_wait_counter (load, decrement, zero flag); the FSM and arbitration stay in the top module.

Verification
REQ-038 WAIT_CYCLES=1, CPU read of 0x10 with memory returning 0xDEADBEEF -> cpu_ready at cycle 3 with cpu_rdata=0xDEADBEEF, and mem_en high for 2 cycles.
REQ-039 WAIT_CYCLES=0, loader write 0x00000013 to 0x0 -> a single mem_we cycle with that addr/data, and ldr_ready at cycle 2.
REQ-040 Both ports request continuously, with ARB_ROUND_ROBIN_EN -> grants LDR, CPU, LDR, CPU; without the macro -> LDR every time while ldr_req stays high.
REQ-041 Reset asserted in WAIT during a write -> no ready pulse, mem_we=0 next cycle, and the FSM in IDLE.
REQ-042 cpu_req dropped in the ACCESS cycle -> the transaction completes, cpu_ready pulses once, and no second grant follows.
REQ-043 Back-to-back CPU reads to 0x4 and 0x8 -> two ready pulses 4 cycles apart (WAIT_CYCLES=1), and cpu_stall low only in the ready cycles.
